window_addr_gen: RTL
====================

WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- ADDR_W, 32, address width.
- IMG_W, 146, input image width in pixels.
- IMG_H, 146, input image height in pixels.
- WIN, 5, read window edge (WIN*WIN reads per position).
- OWIN, 3, write block edge (OWIN*OWIN writes per position).
- STRIDE, 1, window step in pixels.
- RD_BASE, 0, read base address.
- WR_BASE, 32'h0001_0000, write base address.
- BPP, 4, address step per pixel/word.
- RD_LAT, 2, read latency in cycles, 1 or more.
- WR_LAT, 2, write latency in cycles, 1 or more.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- i_start, in, 1, one-cycle start pulse.
- i_inc_raddr, in, 1, consume current read address.
- i_inc_waddr, in, 1, consume current write address.
- o_raddr, out, ADDR_W, current read address.
- o_waddr, out, ADDR_W, current write address.
- o_r_ready, out, 1, o_raddr valid and may be consumed.
- o_w_ready, out, 1, o_waddr valid and may be consumed.
- o_busy, out, 1, frame in progress.
- o_done, out, 1, frame complete, sticky.
- o_pos_row, out, 16, window top row.
- o_pos_col, out, 16, window left column.

Function
REQ-003 SHALL define PX=(IMG_W-WIN)/STRIDE+1 and PY=(IMG_H-WIN)/STRIDE+1 window positions, row-major; defaults give 142x142=20164.
REQ-004 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-005 SHALL, on i_start in IDLE or DONE, enter READ on the next edge with pos=(0,0), read index 0, write index 0, o_done=0 and o_busy=1; i_start in READ/WRITE SHALL be ignored.
REQ-006 SHALL present o_raddr = RD_BASE + ((pos_row+wr)*IMG_W + pos_col+wc)*BPP, with wr/wc iterating row-major over 0..WIN-1.
REQ-007 SHALL present o_waddr = WR_BASE + (pos_idx*OWIN*OWIN + k)*BPP, with pos_idx = pos_row/STRIDE*PX + pos_col/STRIDE and k = 0..OWIN*OWIN-1.
REQ-008 SHALL accept i_inc_raddr only when state=READ and o_r_ready=1; at the accepting edge the read index SHALL advance and o_r_ready SHALL go low for exactly RD_LAT cycles.
REQ-009 SHALL accept i_inc_waddr only when state=WRITE and o_w_ready=1; at the accepting edge the write index SHALL advance and o_w_ready SHALL go low for exactly WR_LAT cycles.
REQ-010 SHALL ignore inc requests that arrive while ready is low or in the wrong state; they SHALL not be queued.
REQ-011 SHALL, if i_inc_raddr and i_inc_waddr are asserted together, honour only the one matching the current state.
REQ-012 SHALL, after accepting the WIN*WIN-th read and once RD_LAT has elapsed, enter WRITE with o_w_ready=1 and o_r_ready=0.
REQ-013 SHALL, after accepting the OWIN*OWIN-th write and once WR_LAT has elapsed, advance pos_col by STRIDE, wrapping to 0 and advancing pos_row by STRIDE at the row end, then re-enter READ.
REQ-014 SHALL, after the final write of position (PY-1,PX-1) and once WR_LAT has elapsed, enter DONE with o_busy=0, o_done=1 and both readies 0; o_done SHALL hold until i_start or rst.
REQ-015 SHALL compute address arithmetic modulo 2^ADDR_W, with no overflow flag.
REQ-016 SHALL hold o_raddr/o_waddr stable except at accepting edges and position advances.
REQ-017 SHALL treat WIN>IMG_W, WIN>IMG_H, RD_LAT=0 or WR_LAT=0 as illegal, enforced by an elaboration-time check.

Reset
REQ-018 SHALL, on rst assertion at any time including mid-frame, immediately force state=IDLE, o_raddr=RD_BASE, o_waddr=WR_BASE, o_r_ready=0, o_w_ready=0, o_busy=0, o_done=0, pos=(0,0).
REQ-019 SHALL resume only on a fresh i_start after rst deasserts; no partial-frame state SHALL survive reset.

Verification
REQ-020 Reset/start: assert rst, release, pulse i_start -> next edge o_r_ready=1, o_raddr=0, o_busy=1.
REQ-021 Window sweep, defaults: 25 accepted reads at pos (0,0) -> o_raddr sequence 0,4,...,16 then 584 (=146*4), ..., final 2352; then o_w_ready=1, o_waddr=0x10000.
REQ-022 Latency/ignore: inc held 3 cycles with RD_LAT=2 -> exactly one advance; ready low exactly 2 cycles; i_inc_waddr during READ has no effect.
REQ-023 Row wrap, IMG_W=IMG_H=6, WIN=3, OWIN=1: after position (0,3) completes -> pos=(1,0), first o_raddr=24; after 16 positions -> o_done=1, last o_waddr=WR_BASE+60.
REQ-024 Mid-operation reset: assert rst during WRITE of position 5 -> all outputs at reset values in the same cycle; new i_start restarts at (0,0).
REQ-025 Full default frame: 20164 positions x (25 reads + 9 writes) -> o_done=1 and final o_waddr=WR_BASE+(20164*9-1)*4.

Source files
------------

// File: rtl/window_addr_gen.sv
// Sliding-window address generator: for each window position it emits WIN*WIN
// read addresses, then OWIN*OWIN write addresses, each handshake followed by a latency gap.
module window_addr_gen #(
  parameter int                ADDR_W  = 32,
  parameter int                IMG_W   = 146,
  parameter int                IMG_H   = 146,
  parameter int                WIN     = 5,
  parameter int                OWIN    = 3,
  parameter int                STRIDE  = 1,
  parameter logic [ADDR_W-1:0] RD_BASE = '0,
  parameter logic [ADDR_W-1:0] WR_BASE = ADDR_W'(32'h0001_0000),
  parameter int                BPP     = 4,
  parameter int                RD_LAT  = 2,
  parameter int                WR_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_inc_raddr,
  input  logic              i_inc_waddr,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_r_ready,
  output logic              o_w_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_pos_row,
  output logic [15:0]       o_pos_col
);

  localparam int PX = (IMG_W - WIN) / STRIDE + 1;
  localparam int PY = (IMG_H - WIN) / STRIDE + 1;

  localparam logic [15:0] WIN_M1   = 16'(WIN - 1);
  localparam logic [15:0] OBLK_M1  = 16'(OWIN * OWIN - 1);
  localparam logic [15:0] LAST_COL = 16'((PX - 1) * STRIDE);
  localparam logic [15:0] LAST_ROW = 16'((PY - 1) * STRIDE);
  localparam logic [15:0] STEP     = 16'(STRIDE);
  localparam logic [15:0] RD_LAT_C = 16'(RD_LAT);
  localparam logic [15:0] WR_LAT_C = 16'(WR_LAT);

  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BPP_A   = ADDR_W'(BPP);
  localparam logic [ADDR_W-1:0] OBLK_A  = ADDR_W'(OWIN * OWIN);

  if (WIN > IMG_W || WIN > IMG_H || RD_LAT < 1 || WR_LAT < 1 || STRIDE < 1) begin : g_illegal
    $error("window_addr_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       wr, wr_nxt, wc, wc_nxt, k, k_nxt;
  logic [15:0]       pos_row, pos_row_nxt, pos_col, pos_col_nxt;
  logic [ADDR_W-1:0] pos_idx, pos_idx_nxt;
  logic [15:0]       lat_cnt, lat_nxt;
  logic              last, last_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr      <= '0;
      wc      <= '0;
      k       <= '0;
      pos_row <= '0;
      pos_col <= '0;
      pos_idx <= '0;
      lat_cnt <= '0;
      last    <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr      <= wr_nxt;
      wc      <= wc_nxt;
      k       <= k_nxt;
      pos_row <= pos_row_nxt;
      pos_col <= pos_col_nxt;
      pos_idx <= pos_idx_nxt;
      lat_cnt <= lat_nxt;
      last    <= last_nxt;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    wr_nxt      = wr;
    wc_nxt      = wc;
    k_nxt       = k;
    pos_row_nxt = pos_row;
    pos_col_nxt = pos_col;
    pos_idx_nxt = pos_idx;
    lat_nxt     = lat_cnt;
    last_nxt    = last;

    unique case (state)
      IDLE, DONE: begin
        if (i_start) begin
          state_nxt   = READ;
          wr_nxt      = '0;
          wc_nxt      = '0;
          k_nxt       = '0;
          pos_row_nxt = '0;
          pos_col_nxt = '0;
          pos_idx_nxt = '0;
          lat_nxt     = '0;
          last_nxt    = 1'b0;
        end
      end
      READ: begin
        if (lat_cnt != '0) begin
          lat_nxt = lat_cnt - 16'd1;
          if (lat_cnt == 16'd1 && last) begin
            state_nxt = WRITE;
            last_nxt  = 1'b0;
          end
        end else if (i_inc_raddr) begin
          lat_nxt = RD_LAT_C;
          // The final read of a block keeps its address on the bus until the block ends.
          if (wr == WIN_M1 && wc == WIN_M1) begin
            last_nxt = 1'b1;
          end else if (wc == WIN_M1) begin
            wc_nxt = '0;
            wr_nxt = wr + 16'd1;
          end else begin
            wc_nxt = wc + 16'd1;
          end
        end
      end
      WRITE: begin
        if (lat_cnt != '0) begin
          lat_nxt = lat_cnt - 16'd1;
          if (lat_cnt == 16'd1 && last) begin
            last_nxt = 1'b0;
            if (pos_row == LAST_ROW && pos_col == LAST_COL) begin
              state_nxt = DONE;
            end else begin
              state_nxt   = READ;
              wr_nxt      = '0;
              wc_nxt      = '0;
              k_nxt       = '0;
              pos_idx_nxt = pos_idx + 1'b1;
              if (pos_col == LAST_COL) begin
                pos_col_nxt = '0;
                pos_row_nxt = pos_row + STEP;
              end else begin
                pos_col_nxt = pos_col + STEP;
              end
            end
          end
        end else if (i_inc_waddr) begin
          lat_nxt = WR_LAT_C;
          if (k == OBLK_M1) last_nxt = 1'b1;
          else              k_nxt    = k + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_raddr   = RD_BASE + ((ADDR_W'(pos_row) + ADDR_W'(wr)) * IMG_W_A
                              + ADDR_W'(pos_col) + ADDR_W'(wc)) * BPP_A;
  assign o_waddr   = WR_BASE + (pos_idx * OBLK_A + ADDR_W'(k)) * BPP_A;
  assign o_r_ready = (state == READ)  && (lat_cnt == '0);
  assign o_w_ready = (state == WRITE) && (lat_cnt == '0);
  assign o_busy    = (state == READ) || (state == WRITE);
  assign o_done    = (state == DONE);
  assign o_pos_row = pos_row;
  assign o_pos_col = pos_col;

endmodule
